// File: rtl/led_pwm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_pwm_pkg: mode encoding, register map and field offsets for led_pwm_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
package led_pwm_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_t;

  localparam int CTRL_ADDR = 0;
  localparam int CH_BASE   = 1;
  localparam int EN_BIT    = 0;
  localparam int P_LSB     = 16;
  localparam int MODE_LSB  = 0;
  localparam int MODE_W    = 2;
  localparam int DUTY_LSB  = 16;
  localparam int BLINK_BIT = 31;

  function automatic logic led_level(input led_mode_t mode, input logic blink, input logic pwm_on);
    case (mode)
      LED_ON:    return 1'b1;
      LED_BLINK: return blink;
      LED_PWM:   return pwm_on;
      default:   return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_timebase.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_pwm_timebase: shared prescaler, PWM counter and blink phase
// Rev 1.0
// ----------------------------------------------------------------------------
module led_pwm_timebase #(
  parameter int PRESCALE_W = 16,
  parameter int PWM_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_restart,
  input  logic [PRESCALE_W-1:0] i_p,
  output logic [PWM_W-1:0]      o_pwm_cnt,
  output logic                  o_blink_phase
);

  logic [PRESCALE_W-1:0] r_pcnt;
  logic [PWM_W-1:0]      r_pwm_cnt;
  logic                  r_blink;
  logic                  w_tick;
  logic                  w_wrap;

  assign w_tick = (r_pcnt == i_p);
  assign w_wrap = (r_pwm_cnt == {PWM_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n || i_restart || !i_en) begin
      r_pcnt    <= '0;
      r_pwm_cnt <= '0;
      r_blink   <= 1'b0;
    end else if (w_tick) begin
      r_pcnt    <= '0;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      // Blink half-period is one full PWM period
      if (w_wrap) begin
        r_blink <= ~r_blink;
      end
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  assign o_pwm_cnt     = r_pwm_cnt;
  assign o_blink_phase = r_blink;

endmodule
`default_nettype wire

// File: rtl/led_pwm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_pwm_ctrl: Avalon-MM slave driving NUM_CH LEDs in off/on/blink/PWM modes
// Rev 1.0
// ----------------------------------------------------------------------------
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int PWM_W      = 8,
  parameter int PRESCALE_W = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] led_out
);

  localparam int STATUS_ADDR = CH_BASE + NUM_CH;

  logic                  r_en;
  logic [PRESCALE_W-1:0] r_p;
  led_mode_t             r_mode [NUM_CH];
  logic [PWM_W-1:0]      r_duty [NUM_CH];
  logic [NUM_CH-1:0]     r_led;
  logic [31:0]           r_readdata;

  logic                  w_ctrl_wr;
  logic [NUM_CH-1:0]     w_ch_wr;
  logic [NUM_CH-1:0]     w_led_nxt;
  logic [PWM_W-1:0]      w_pwm_cnt;
  logic                  w_blink;
  logic [31:0]           w_rdata;
  logic                  w_unused_wdata;

  assign w_ctrl_wr      = avs_write && (avs_address == ADDR_W'(CTRL_ADDR));
  assign w_unused_wdata = ^avs_writedata;

  led_pwm_timebase #(
    .PRESCALE_W (PRESCALE_W),
    .PWM_W      (PWM_W)
  ) u_timebase (
    .clk           (clk_clk),
    .rst_n         (reset_reset_n),
    .i_en          (r_en),
    .i_restart     (w_ctrl_wr),
    .i_p           (r_p),
    .o_pwm_cnt     (w_pwm_cnt),
    .o_blink_phase (w_blink)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_ch_wr[i]   = avs_write && (avs_address == ADDR_W'(CH_BASE + i));
    assign w_led_nxt[i] = r_en && led_level(r_mode[i], w_blink, (w_pwm_cnt < r_duty[i]));
  end

  always_comb begin
    w_rdata = '0;
    if (avs_address == ADDR_W'(CTRL_ADDR)) begin
      w_rdata[EN_BIT]              = r_en;
      w_rdata[P_LSB +: PRESCALE_W] = r_p;
    end else if (avs_address == ADDR_W'(STATUS_ADDR)) begin
      w_rdata[NUM_CH-1:0] = r_led;
      w_rdata[BLINK_BIT]  = w_blink;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (avs_address == ADDR_W'(CH_BASE + i)) begin
        w_rdata[MODE_LSB +: MODE_W] = r_mode[i];
        w_rdata[DUTY_LSB +: PWM_W]  = r_duty[i];
      end
    end
  end

  // Read data is captured from pre-write state, so a same-address write is not visible
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_en       <= 1'b0;
      r_p        <= '0;
      r_led      <= '0;
      r_readdata <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_mode[i] <= LED_OFF;
        r_duty[i] <= '0;
      end
    end else begin
      if (w_ctrl_wr) begin
        r_en <= avs_writedata[EN_BIT];
        r_p  <= avs_writedata[P_LSB +: PRESCALE_W];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_ch_wr[i]) begin
          r_mode[i] <= led_mode_t'(avs_writedata[MODE_LSB +: MODE_W]);
          r_duty[i] <= avs_writedata[DUTY_LSB +: PWM_W];
        end
      end
      r_led <= w_led_nxt;
      if (avs_read) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign avs_readdata = r_readdata;
  assign led_out      = r_led;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_led_pwm_ctrl: directed self-checking bench for led_pwm_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_led_pwm_ctrl;

  localparam int NUM_CH     = 4;
  localparam int PWM_W      = 8;
  localparam int PRESCALE_W = 16;
  localparam int ADDR_W     = 4;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic [NUM_CH-1:0] led_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_clk = ~clk_clk;

  led_pwm_ctrl #(
    .NUM_CH     (NUM_CH),
    .PWM_W      (PWM_W),
    .PRESCALE_W (PRESCALE_W),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .led_out       (led_out)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    adv(1);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic [NUM_CH-1:0] snap);
    avs_address = a;
    avs_read    = 1'b1;
    snap        = led_out;
    adv(1);
    avs_read    = 1'b0;
    adv(1);
    d = avs_readdata;
  endtask

  task automatic count_hi(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      if (led_out[ch]) hi++;
      adv(1);
    end
  endtask

  logic [31:0]       rdata;
  logic [NUM_CH-1:0] snap;
  int                hi;
  int                errs;
  logic              found;

  initial begin
    reset_reset_n = 1'b0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;

    // Reset state
    adv(2);
    chk("reset_led", 32'(led_out), 32'h0);
    chk("reset_rdata", avs_readdata, 32'h0);
    reset_reset_n = 1'b1;
    for (int a = 0; a <= NUM_CH + 1; a++) begin
      rd(ADDR_W'(a), rdata, snap);
      chk($sformatf("reset_read_%0d", a), rdata, 32'h0);
    end

    // PWM duty 64 with P=0: high when pwm_cnt < 64, pwm_cnt = j+1 at sample j
    wr(4'd0, 32'h0000_0001);
    wr(4'd1, 32'h0040_0003);
    adv(1);
    errs = 0;
    hi   = 0;
    for (int j = 0; j < 256; j++) begin
      if (led_out[0]) hi++;
      if (led_out[0] !== (((j + 1) % 256) < 64)) errs++;
      adv(1);
    end
    chk("pwm64_count", 32'(hi), 32'd64);
    chk("pwm64_pattern", 32'(errs), 32'd0);

    wr(4'd1, 32'h00FF_0003);
    adv(1);
    count_hi(0, 256, hi);
    chk("pwm255_count", 32'(hi), 32'd255);

    wr(4'd1, 32'h0000_0003);
    adv(1);
    count_hi(0, 256, hi);
    chk("pwm0_count", 32'(hi), 32'd0);

    // Blink with P=1: tick every 2 cycles, phase flips every 512 cycles
    wr(4'd0, 32'h0001_0001);
    wr(4'd2, 32'h0000_0002);
    adv(511);
    chk("blink_lo_512", 32'(led_out[1]), 32'h0);
    adv(1);
    chk("blink_hi_513", 32'(led_out[1]), 32'h1);
    rd(4'd5, rdata, snap);
    chk("status_blink1", rdata, 32'h8000_0000 | 32'(snap));
    adv(509);
    chk("blink_hi_1024", 32'(led_out[1]), 32'h1);
    adv(1);
    chk("blink_lo_1025", 32'(led_out[1]), 32'h0);

    // Global enable gating and enable latency
    wr(4'd0, 32'h0000_0000);
    wr(4'd3, 32'h0000_0001);
    adv(3);
    chk("en0_all_off", 32'(led_out), 32'h0);
    wr(4'd0, 32'h0000_0001);
    chk("en1_e0", 32'(led_out[2]), 32'h0);
    adv(1);
    chk("en1_e1", 32'(led_out[2]), 32'h1);

    // Register readback
    wr(4'd4, 32'h00AB_0003);
    rd(4'd4, rdata, snap);
    chk("read_ch3", rdata, 32'h00AB_0003);
    rd(4'd15, rdata, snap);
    chk("read_unmapped", rdata, 32'h0);
    rd(4'd0, rdata, snap);
    chk("read_ctrl", rdata, 32'h0000_0001);
    rd(4'd2, rdata, snap);
    chk("read_ch1", rdata, 32'h0000_0002);
    rd(4'd5, rdata, snap);
    chk("status_blink0", rdata, 32'(snap));
    chk("status_ch2_ch1", 32'(snap[2:1]), 32'h2);

    avs_address   = 4'd4;
    avs_writedata = 32'h0012_0001;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    adv(1);
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    adv(1);
    chk("rw_same_addr", avs_readdata, 32'h00AB_0003);
    rd(4'd4, rdata, snap);
    chk("rw_after", rdata, 32'h0012_0001);

    wr(4'd1, 32'hFFFF_FFFF);
    rd(4'd1, rdata, snap);
    chk("reserved_bits", rdata, 32'h00FF_0003);
    wr(4'd10, 32'hFFFF_FFFF);
    rd(4'd0, rdata, snap);
    chk("unmapped_wr", rdata, 32'h0000_0001);

    // Reset mid-PWM while led_out[0] is high
    wr(4'd1, 32'h0080_0003);
    rd(4'd1, rdata, snap);
    chk("pre_reset_read", rdata, 32'h0080_0003);
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      if (led_out[0]) found = 1'b1;
      else adv(1);
    end
    chk("wait_led0_high", 32'(found), 32'h1);
    reset_reset_n = 1'b0;
    adv(1);
    reset_reset_n = 1'b1;
    chk("midreset_led", 32'(led_out), 32'h0);
    chk("midreset_rdata", avs_readdata, 32'h0);
    adv(2);
    chk("postreset_led", 32'(led_out), 32'h0);
    for (int a = 0; a <= NUM_CH + 1; a++) begin
      rd(ADDR_W'(a), rdata, snap);
      chk($sformatf("postreset_read_%0d", a), rdata, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
